// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer definitions for the write arbiter: screen geometry,
// coordinate widths, requester indices and the arbiter state type.
package fb_write_arbiter_pkg;

   localparam int SCR_W  = 320;
   localparam int SCR_H  = 200;
   localparam int FB_X_W = 9;
   localparam int FB_Y_W = 8;

   localparam int REQ_CLEAR  = 0;
   localparam int REQ_ALIENS = 1;
   localparam int REQ_PLAYER = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic in_screen(input logic [FB_X_W-1:0] x, input logic [FB_Y_W-1:0] y);
      return (int'(x) < SCR_W) && (int'(y) < SCR_H);
   endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of requester beats and the framebuffer write port seen by the arbiter.
// master = producer/framebuffer side, slave = the arbiter itself.
interface fb_write_arbiter_if #(
   parameter int NUM_REQ = 3
);
   import fb_write_arbiter_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*FB_X_W-1:0] req_x;
   logic [NUM_REQ*FB_Y_W-1:0] req_y;
   logic [NUM_REQ-1:0]        req_bit;
   logic [NUM_REQ-1:0]        gnt;
   logic                      wr_en;
   logic [FB_X_W-1:0]         wr_x;
   logic [FB_Y_W-1:0]         wr_y;
   logic                      wr_bit;
   logic                      drop;
   logic                      busy;

   modport master (
      output req, req_last, req_x, req_y, req_bit,
      input  gnt, wr_en, wr_x, wr_y, wr_bit, drop, busy
   );

   modport slave (
      input  req, req_last, req_x, req_y, req_bit,
      output gnt, wr_en, wr_x, wr_y, wr_bit, drop, busy
   );

endinterface

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// (with wrap) from the index after last_idx.
module rr_pick #(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest offset down so the nearest requester is written last and wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = IDX_W'((int'(last_idx) + off) % NUM_REQ);
         if (req[idx]) begin
            winner = idx;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port: one burst per grant,
// bursts capped at MAX_BURST beats, off-screen beats dropped instead of written.
module fb_write_arbiter
   import fb_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int MAX_BURST = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   fb_write_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

   arb_state_e          state, state_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt;
   logic [IDX_W-1:0]    last_idx, last_nxt, winner;
   logic                any_req;
   logic [7:0]          beat_cnt, cnt_nxt;
   logic                wr_en_nxt, wr_bit_nxt, drop_nxt;
   logic [FB_X_W-1:0]   wr_x_nxt, beat_x;
   logic [FB_Y_W-1:0]   wr_y_nxt, beat_y;
   logic                beat_bit, accept;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req      (bus.req),
      .last_idx (last_idx),
      .winner   (winner),
      .any      (any_req)
   );

   // While granted, last_idx is the granted requester, so it selects the beat fields.
   assign beat_x   = bus.req_x[last_idx*FB_X_W +: FB_X_W];
   assign beat_y   = bus.req_y[last_idx*FB_Y_W +: FB_Y_W];
   assign beat_bit = bus.req_bit[last_idx];
   assign accept   = bus.req[last_idx];
   assign bus.busy = (state == GRANT);

   // Next-state and next-output logic; the write port holds its coordinates between writes.
   always_comb begin
      state_nxt  = state;
      gnt_nxt    = bus.gnt;
      last_nxt   = last_idx;
      cnt_nxt    = beat_cnt;
      wr_en_nxt  = 1'b0;
      drop_nxt   = 1'b0;
      wr_x_nxt   = bus.wr_x;
      wr_y_nxt   = bus.wr_y;
      wr_bit_nxt = bus.wr_bit;
      case (state)
         IDLE: begin
            if (enable && any_req) begin
               state_nxt = GRANT;
               gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
               last_nxt  = winner;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               cnt_nxt = beat_cnt + 8'd1;
               if (in_screen(beat_x, beat_y)) begin
                  wr_en_nxt  = 1'b1;
                  wr_x_nxt   = beat_x;
                  wr_y_nxt   = beat_y;
                  wr_bit_nxt = beat_bit;
               end else begin
                  drop_nxt = 1'b1;
               end
            end
            if (!accept || bus.req_last[last_idx] || (beat_cnt == CNT_LAST)) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // State, grant, counter and write-port registers; reset leaves requester 0 first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bus.gnt    <= '0;
         last_idx   <= IDX_W'(NUM_REQ - 1);
         beat_cnt   <= '0;
         bus.wr_en  <= 1'b0;
         bus.wr_x   <= '0;
         bus.wr_y   <= '0;
         bus.wr_bit <= 1'b0;
         bus.drop   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bus.gnt    <= gnt_nxt;
         last_idx   <= last_nxt;
         beat_cnt   <= cnt_nxt;
         bus.wr_en  <= wr_en_nxt;
         bus.wr_x   <= wr_x_nxt;
         bus.wr_y   <= wr_y_nxt;
         bus.wr_bit <= wr_bit_nxt;
         bus.drop   <= drop_nxt;
      end
   end

endmodule
